if_id_buffer: RTL and testbench

//  Fetch->decode pipeline register with a 2-entry skid buffer.

---
 rtl/if_id_buffer.sv | 133 +++++++++++++
 tb/tb_if_id_buffer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// Fetch->decode pipeline register with a 2-entry skid buffer and an
// interrupt hold window that stalls fetch after an interrupt-marked word.
module if_id_buffer #(
  parameter int              DW       = 32,
  parameter logic [DW-1:0]   NOP_WORD = '0,
  parameter int              INT_HOLD = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_instruction,
  input  logic [DW-1:0] i_pc,
  input  logic          i_int,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_stall,
  input  logic          i_flush,
  output logic [DW-1:0] o_instruction,
  output logic [DW-1:0] o_pc,
  output logic          o_int,
  output logic          o_valid
);

  typedef enum logic {RUN, HOLD} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          main_vld_q, main_vld_d;
  logic          skid_vld_q, skid_vld_d;
  logic [DW-1:0] main_instr_q, main_instr_d;
  logic [DW-1:0] main_pc_q, main_pc_d;
  logic          main_int_q, main_int_d;
  logic [DW-1:0] skid_instr_q, skid_instr_d;
  logic [DW-1:0] skid_pc_q, skid_pc_d;
  logic          skid_int_q, skid_int_d;
  logic          accept_in;
  logic          take_out;

  // o_ready depends only on registered state, never on i_valid / i_stall
  always_comb begin
    o_ready       = (state_q == RUN) && !skid_vld_q;
    o_valid       = main_vld_q;
    o_instruction = main_vld_q ? main_instr_q : NOP_WORD;
    o_pc          = main_vld_q ? main_pc_q : '0;
    o_int         = main_vld_q && main_int_q;
    accept_in     = i_valid && o_ready;
    take_out      = main_vld_q && !i_stall;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_flush) begin
      state_d = RUN;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept_in && i_int) begin
            state_d = HOLD;
            cnt_d   = 4'(INT_HOLD - 1);
          end
        end
        HOLD: begin
          if (cnt_q == 4'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    main_vld_d   = main_vld_q;
    skid_vld_d   = skid_vld_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    main_int_d   = main_int_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_int_d   = skid_int_q;
    if (i_flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || take_out) begin
      if (skid_vld_q) begin
        // Skid is older than any incoming word, so it moves up first
        main_vld_d   = 1'b1;
        main_instr_d = skid_instr_q;
        main_pc_d    = skid_pc_q;
        main_int_d   = skid_int_q;
        skid_vld_d   = accept_in;
        skid_instr_d = i_instruction;
        skid_pc_d    = i_pc;
        skid_int_d   = i_int;
      end else begin
        main_vld_d   = accept_in;
        main_instr_d = i_instruction;
        main_pc_d    = i_pc;
        main_int_d   = i_int;
      end
    end else if (accept_in) begin
      skid_vld_d   = 1'b1;
      skid_instr_d = i_instruction;
      skid_pc_d    = i_pc;
      skid_int_d   = i_int;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= 4'd0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // Payload registers are qualified by the valid bits, so they carry no reset
  always_ff @(posedge clk) begin
    main_instr_q <= main_instr_d;
    main_pc_q    <= main_pc_d;
    main_int_q   <= main_int_d;
    skid_instr_q <= skid_instr_d;
    skid_pc_q    <= skid_pc_d;
    skid_int_q   <= skid_int_d;
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: a 2-deep ordered queue model with an
// interrupt hold window, checked against the DUT on every falling edge.
module tb_if_id_buffer;

  localparam int DW       = 32;
  localparam int INT_HOLD = 2;
  localparam logic [DW-1:0] NOP = 32'h0;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [DW-1:0] pc;
    logic          it;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] i_instruction = '0;
  logic [DW-1:0] i_pc = '0;
  logic          i_int = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic          i_stall = 1'b0;
  logic          i_flush = 1'b0;
  logic [DW-1:0] o_instruction;
  logic [DW-1:0] o_pc;
  logic          o_int;
  logic          o_valid;

  if_id_buffer #(.DW(DW), .NOP_WORD(NOP), .INT_HOLD(INT_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .i_instruction(i_instruction), .i_pc(i_pc),
    .i_int(i_int), .i_valid(i_valid), .o_ready(o_ready), .i_stall(i_stall),
    .i_flush(i_flush), .o_instruction(o_instruction), .o_pc(o_pc),
    .o_int(o_int), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  word_t         exp_q[$];
  logic          exp_ready = 1'b1;
  int            hold_left = 0;
  logic          pend_acc = 1'b0;
  logic          pend_flush = 1'b0;
  word_t         pend_word;
  logic [DW-1:0] pc_ctr = '0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply last cycle's handshake outcome to the model at the clock edge
  task automatic commit();
    if (pend_flush) begin
      exp_q.delete();
      hold_left = 0;
    end else begin
      if (hold_left > 0) hold_left--;
      if (pend_acc) begin
        exp_q.push_back(pend_word);
        if (pend_word.it) hold_left = INT_HOLD;
      end
    end
  endtask

  task automatic step(input logic v, input logic it, input logic st, input logic fl);
    @(posedge clk);
    commit();
    #2;
    i_valid       = v;
    i_pc          = pc_ctr;
    i_instruction = $urandom;
    i_int         = it;
    i_stall       = st;
    i_flush       = fl;
    exp_ready     = (hold_left == 0) && (exp_q.size() < 2);
    pend_acc      = v && exp_ready;
    pend_flush    = fl;
    pend_word     = '{instr: i_instruction, pc: i_pc, it: it};
    if (pend_acc) pc_ctr = pc_ctr + 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(o_valid), 64'd0);
    chk({tag, "_instr"}, 64'(o_instruction), 64'(NOP));
    chk({tag, "_pc"}, 64'(o_pc), 64'd0);
    chk({tag, "_int"}, 64'(o_int), 64'd0);
    chk({tag, "_ready"}, 64'(o_ready), 64'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    commit();
    #2;
    i_valid = 1'b0; i_flush = 1'b0; i_stall = 1'b1; i_int = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    hold_left  = 0;
    exp_ready  = 1'b1;
    pend_acc   = 1'b0;
    pend_flush = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compares handshake state every cycle and pops words as decode takes them
  always @(negedge clk) begin
    word_t w;
    chk("o_ready", 64'(o_ready), 64'(exp_ready));
    chk("o_valid", 64'(o_valid), 64'(exp_q.size() != 0));
    if (o_valid && exp_q.size() != 0) begin
      w = exp_q[0];
      chk("o_pc", 64'(o_pc), 64'(w.pc));
      chk("o_instruction", 64'(o_instruction), 64'(w.instr));
      chk("o_int", 64'(o_int), 64'(w.it));
      if (!i_stall) void'(exp_q.pop_front());
    end else if (!o_valid) begin
      chk("idle_instr", 64'(o_instruction), 64'(NOP));
      chk("idle_pc", 64'(o_pc), 64'd0);
      chk("idle_int", 64'(o_int), 64'd0);
    end
  end

  initial begin
    #1;
    check_reset_outputs("rst");
    @(posedge clk); #2; rst_n = 1'b1;

    // Back-to-back stream
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    // Stall for 3 cycles while fetch keeps offering, then release
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Interrupt word into an empty buffer, then watch the hold window
    pc_ctr = 32'd8;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Fill both slots under stall, then flush with a word offered
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Flush in the first hold cycle
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Async reset while stalled with both slots full, then one word
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1 && (i == 2), 1'b1, 1'b0);
    pulse_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, ($urandom % 10) == 0, ($urandom % 3) == 0,
           ($urandom % 25) == 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    commit();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
